// File: rtl/alm_pkg.sv
// Shared FSM state encoding and default widths for the product accumulator.
package alm_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 16;
  localparam int PROD_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alm_sat_add.sv
// Signed saturating add of an accumulator and a one's-complement product.
// Combinational; the product's sign bit is the carry-in that makes it two's complement.
module alm_sat_add
  import alm_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] p_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam int EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] p_ext;
  logic [EXT_W-1:0] cin_ext;
  logic [EXT_W-1:0] raw;

  assign a_ext   = {a_i[ACC_W-1], a_i};
  assign p_ext   = {{(EXT_W-PROD_W){p_i[PROD_W-1]}}, p_i};
  assign cin_ext = {{(EXT_W-1){1'b0}}, p_i[PROD_W-1]};
  assign raw     = a_ext + p_ext + cin_ext;

  // One guard bit: the top bit is the true sign, a disagreement below it is overflow.
  always_comb begin
    ovf_o = raw[ACC_W] ^ raw[ACC_W-1];
    sum_o = raw[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/alm_prod_acc.sv
// Per-packet saturating accumulator of log-multiplier products; result 1 cycle after last beat.
// Beats accepted every cycle until a result is pending; in_ready_o drops while the result waits.
module alm_prod_acc
  import alm_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] p_i,
  input  logic              last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  assign accept = in_valid_i & in_ready_o;
  // A zero addend on the first beat turns the adder into the packet load path.
  assign add_a  = (state_q == ST_IDLE) ? '0 : acc_q;

  alm_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a_i   (add_a),
    .p_i   (p_i),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (accept) state_d = last_i ? ST_HOLD : ST_ACC;
      ST_HOLD:         if (out_ready_i) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q != ST_HOLD);
    out_valid_o = (state_q == ST_HOLD);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      acc_d = add_sum;
      if (state_q == ST_IDLE) begin
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o   = acc_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_alm_prod_acc.sv
// Scoreboard bench: two widths (40/16 and 34/3) share stimulus; a forked monitor checks results.
module tb_alm_prod_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] p;
  logic        last;
  logic        out_ready;

  logic        rdy40, vld40, ovf40;
  logic [39:0] sum40;
  logic [15:0] cnt40;
  logic        rdy34, vld34, ovf34;
  logic [33:0] sum34;
  logic [2:0]  cnt34;

  alm_prod_acc dut40 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy40),
    .p_i(p), .last_i(last), .out_valid_o(vld40), .out_ready_i(out_ready),
    .sum_o(sum40), .count_o(cnt40), .ovf_o(ovf40)
  );

  alm_prod_acc #(.ACC_W(34), .CNT_W(3)) dut34 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy34),
    .p_i(p), .last_i(last), .out_valid_o(vld34), .out_ready_i(out_ready),
    .sum_o(sum34), .count_o(cnt34), .ovf_o(ovf34)
  );

  typedef struct {
    longint s40; longint c40; bit o40;
    longint s34; longint c34; bit o34;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: integer sum with clamping at every step, sticky flag, clamped count.
  function automatic void model(input logic [31:0] vals[$], input int accw, input int cntw,
                                output longint s, output longint c, output bit o);
    longint mx, mn, t;
    logic [31:0] nv;
    mx = (longint'(1) << (accw - 1)) - 1;
    mn = -mx - 1;
    s = 0; c = 0; o = 1'b0;
    foreach (vals[i]) begin
      nv = ~vals[i];
      t  = vals[i][31] ? -longint'({32'd0, nv}) : longint'({32'd0, vals[i]});
      s  = s + t;
      if (s > mx) begin s = mx; o = 1'b1; end
      if (s < mn) begin s = mn; o = 1'b1; end
      if (c < (longint'(1) << cntw) - 1) c = c + 1;
    end
  endfunction

  task automatic drive_beat(input logic [31:0] v, input logic lst);
    int guard = 0;
    in_valid = 1'b1;
    p        = v;
    last     = lst;
    while (!rdy40 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [31:0] vals[$], input int maxgap, input bit final_pkt);
    exp_t e;
    if (final_pkt) begin
      model(vals, 40, 16, e.s40, e.c40, e.o40);
      model(vals, 34, 3, e.s34, e.c34, e.o34);
      exp_q.push_back(e);
    end
    foreach (vals[i]) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      drive_beat(vals[i], final_pkt && (i == vals.size() - 1));
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk); guard++;
    end
    #1;
    chk("drain", longint'(exp_q.size()), 0);
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 255));
      2:       v = 32'h7FFF_0000 | 32'($urandom_range(0, 65535));
      default: v = 32'h8000_0000 | 32'($urandom_range(0, 65535));
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] vals[$];
    in_valid  = 1'b0;
    p         = '0;
    last      = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    fork
      forever begin
        @(posedge clk); #1;
        out_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
      end
      begin : monitor
        bit held = 1'b0;
        longint hs40 = 0, hc40 = 0, hs34 = 0, hc34 = 0;
        bit ho40 = 1'b0, ho34 = 1'b0;
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            held = 1'b0;
          end else begin
            if (held) begin
              chk("hold_vld", vld40, 1);
              chk("hold_sum40", longint'($signed(sum40)), hs40);
              chk("hold_cnt40", longint'(cnt40), hc40);
              chk("hold_ovf40", ovf40, ho40);
              chk("hold_sum34", longint'($signed(sum34)), hs34);
              chk("hold_cnt34", longint'(cnt34), hc34);
              chk("hold_ovf34", ovf34, ho34);
            end
            held = 1'b0;
            if (vld40 || vld34) begin
              if (out_ready) begin
                if (exp_q.size() == 0) begin
                  chk("unexpected_out", 1, 0);
                end else begin
                  e = exp_q.pop_front();
                  chk("vld40", vld40, 1);
                  chk("vld34", vld34, 1);
                  chk("sum40", longint'($signed(sum40)), e.s40);
                  chk("cnt40", longint'(cnt40), e.c40);
                  chk("ovf40", ovf40, e.o40);
                  chk("sum34", longint'($signed(sum34)), e.s34);
                  chk("cnt34", longint'(cnt34), e.c34);
                  chk("ovf34", ovf34, e.o34);
                end
              end else begin
                held = 1'b1;
                hs40 = longint'($signed(sum40)); hc40 = longint'(cnt40); ho40 = ovf40;
                hs34 = longint'($signed(sum34)); hc34 = longint'(cnt34); ho34 = ovf34;
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld40", vld40, 0);
    chk("rst_sum40", longint'(sum40), 0);
    chk("rst_cnt40", longint'(cnt40), 0);
    chk("rst_ovf40", ovf40, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy40", rdy40, 1);
    chk("rst_rdy34", rdy34, 1);

    // Single beat 100; result held 5 cycles, accepted on the 6th
    rdy_mode = 1;
    vals = '{32'h0000_0064};
    send_packet(vals, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold5_vld", vld40, 1);
      chk("hold5_inrdy", rdy40, 0);
      if (i == 0) begin
        chk("single_sum", longint'($signed(sum40)), 100);
        chk("single_cnt", longint'(cnt40), 1);
        chk("single_ovf", ovf40, 0);
      end
      if (i == 4) rdy_mode = 2;
      @(posedge clk);
    end
    #2;
    chk("hold6_vld", vld40, 1);
    @(posedge clk); #2;
    chk("idle_vld", vld40, 0);
    chk("idle_inrdy", rdy40, 1);
    rdy_mode = 0;
    wait_drain();

    // -100 + 200
    rdy_mode = 1;
    vals = '{32'hFFFF_FF9B, 32'h0000_00C8};
    send_packet(vals, 0, 1'b1);
    #1;
    chk("neg_sum", longint'($signed(sum40)), 100);
    chk("neg_cnt", longint'(cnt40), 2);
    rdy_mode = 0;
    wait_drain();

    // Positive saturation at 34 bits
    rdy_mode = 1;
    vals = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    send_packet(vals, 0, 1'b1);
    #1;
    chk("sat_sum34", longint'(sum34), 64'h1_FFFF_FFFF);
    chk("sat_ovf34", ovf34, 1);
    chk("sat_cnt40", longint'(cnt40), 5);
    rdy_mode = 0;
    wait_drain();

    // Negative saturation, then ovf stays sticky while pulling back in range
    vals = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    send_packet(vals, 1, 1'b1);
    wait_drain();

    // Reset mid-packet discards it
    vals = '{32'h10, 32'h10, 32'h10};
    send_packet(vals, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld40", vld40, 0);
    chk("midrst_vld34", vld34, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_rdy", rdy40, 1);
    chk("midrst_cnt", longint'(cnt40), 0);
    rdy_mode = 1;
    vals = '{32'h5};
    send_packet(vals, 0, 1'b1);
    #1;
    chk("postrst_sum", longint'($signed(sum40)), 5);
    chk("postrst_cnt", longint'(cnt40), 1);
    rdy_mode = 0;
    wait_drain();

    // 1..4 with random gaps
    rdy_mode = 1;
    vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_packet(vals, 3, 1'b1);
    #1;
    chk("gap_sum", longint'($signed(sum40)), 10);
    chk("gap_cnt", longint'(cnt40), 4);
    rdy_mode = 0;
    wait_drain();

    // Random packets, some long enough to clamp the 3-bit count
    for (int n = 0; n < 40; n++) begin
      vals.delete();
      repeat ($urandom_range(1, 12)) vals.push_back(rand_val());
      send_packet(vals, 2, 1'b1);
    end
    wait_drain();

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alm_prod_acc.md
ALM_PROD_ACC -- requirements
Module: alm_prod_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator/result width in bits (legal range 33..64).
REQ-002 SHALL have parameter CNT_W, default 16, beat-counter width in bits.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_i  input  1  product beat valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept a beat.
REQ-007 SHALL have port p_i  input  32  product from the upstream log multiplier; one's-complement encoded when negative.
REQ-008 SHALL have port last_i  input  1  marks the final beat of a packet.
REQ-009 SHALL have port out_valid_o  output  1  result valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port sum_o  output  ACC_W  signed packet sum.
REQ-012 SHALL have port count_o  output  CNT_W  beats accumulated in the packet.
REQ-013 SHALL have port ovf_o  output  1  saturation occurred within the packet.

Function
REQ-014 SHALL accept a beat only in a cycle where in_valid_i and in_ready_o are both 1.
REQ-015 SHALL form each term as sign-extend(p_i) to ACC_W plus p_i[31] as carry-in, converting one's-complement to two's-complement.
REQ-016 SHALL implement FSM states IDLE, ACC, HOLD; in_ready_o = 1 in IDLE and ACC, 0 in HOLD; out_valid_o = 1 only in HOLD.
REQ-017 SHALL, in IDLE on an accepted beat, load acc = term, count = 1, ovf = 0; go to HOLD if last_i else ACC.
REQ-018 SHALL, in ACC on an accepted beat, set acc = sat(acc + term), count += 1; go to HOLD if last_i.
REQ-019 SHALL hold state, acc, count and ovf unchanged in IDLE/ACC during cycles with no accepted beat (gaps allowed, any length).
REQ-020 SHALL saturate signed to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set ovf sticky until the next packet load.
REQ-021 SHALL saturate count at 2^CNT_W-1 without wrap.
REQ-022 SHALL assert out_valid_o the cycle after the accepted last beat (latency 1) and keep sum_o, count_o, ovf_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL return to IDLE on the cycle out_valid_o and out_ready_i are both 1; no beat is accepted that cycle.
REQ-024 SHALL sustain one accepted beat per cycle inside a packet; minimum one-cycle bubble between packets.

Reset
REQ-025 SHALL, while rst_ni=0, force state IDLE, acc 0, count 0, ovf 0, out_valid_o 0, in_ready_o 1 after release.
REQ-026 SHALL discard any partial packet or pending result on reset with no output produced.

Structure
REQ-027 SHALL place the FSM state enum and default ACC_W/CNT_W constants in shared package alm_pkg.
REQ-028 SHALL implement the saturating signed adder with carry-in as sub-module alm_sat_add.

Verification
REQ-029 SHALL cover: single beat p_i=0x00000064, last_i=1 -> next cycle out_valid_o=1, sum_o=100, count_o=1, ovf_o=0.
REQ-030 SHALL cover: beats 0xFFFFFF9B then 0x000000C8 (last) -> sum_o=100, count_o=2.
REQ-031 SHALL cover: result pending with out_ready_i=0 for 5 cycles -> out_valid_o held, outputs stable, in_ready_o=0; accept on cycle 6 -> IDLE next cycle.
REQ-032 SHALL cover: ACC_W=34, five beats 0x7FFFFFFF -> sum_o=0x1FFFFFFFF, ovf_o=1, count_o=5.
REQ-033 SHALL cover: 3 beats of 0x10 then rst_ni low mid-packet -> out_valid_o=0; next packet single beat 0x5 -> sum_o=5, count_o=1.
REQ-034 SHALL cover: 4 beats with random in_valid_i gaps of 0-3 cycles, values 1,2,3,4 -> sum_o=10, count_o=4.
